vga_screen_select: RTL and testbench
====================================

// Module: vga_screen_select
// PURPOSE
//  Output stage after the game-screen and end-screen VGA pipelines (both clocked by CLK_40M, 800x600).
//  Chooses which pipeline drives the VGA pins, using the game-over and restart events from game logic.
//  Switches source only at a frame boundary, which is the leading edge of the current source's Vsync.
//  Blinks the end screen for a fixed number of frames, then holds it steady and pulses Flash_over_sig.
// PARAMETERS
//  SYNC_ACTIVE_HIGH  1    polarity of Hsync/Vsync on both inputs and outputs (1 = active-high)
//  BLINK_FRAMES      15   frames per on/off half-period while blinking
//  FLASH_FRAMES      120  total frames in blink phase (>=1, <=255)
// PORTS
//  CLK_40M          in   1  pixel clock, 40 MHz
//  RST              in   1  asynchronous reset, active-high
//  Game_over_sig    in   1  level; sampled only in PLAY
//  Restart_sig      in   1  single-cycle pulse; sampled only in OVER_FLASH/OVER
//  game_Vga_red/green/blue, game_Hsync_sig, game_Vsync_sig   in  1 each  game pipeline
//  end_Vga_red/green/blue, end_Hsync_sig, end_Vsync_sig      in  1 each  end-screen pipeline
//  Vga_red, Vga_green, Vga_blue     out  1 each  registered pixel colour
//  Hsync_sig, Vsync_sig             out  1 each  registered sync
//  end_active       out  1  1 while the end source drives the pins (OVER_FLASH, OVER, PEND_PLAY)
//  Flash_over_sig   out  1  1-cycle pulse on the OVER_FLASH->OVER transition
// BEHAVIOUR
//  Reset (async, any time, incl. mid-frame): state=PLAY; colours=0; Hsync/Vsync=inactive level
//   (~SYNC_ACTIVE_HIGH); end_active=0; Flash_over_sig=0; counters=0; edge-detect history=inactive.
//  Latency: every output is registered. Output at cycle n+1 = selected inputs at cycle n.
//  Frame edge: a per-source register holds the previous Vsync. A leading edge is prev inactive and
//   current active. Both histories update every cycle, whichever source is selected.
//  FSM (selected source in brackets):
//   PLAY       [game]: Game_over_sig=1 -> PEND_OVER.
//   PEND_OVER  [game]: game Vsync leading edge -> OVER_FLASH; frame_cnt=0.
//   OVER_FLASH [end] : each end Vsync leading edge increments frame_cnt.
//                      frame_cnt reaching FLASH_FRAMES -> OVER, and Flash_over_sig pulses.
//                      Restart_sig -> PEND_PLAY; takes priority over the FLASH_FRAMES exit.
//   OVER       [end] : Restart_sig -> PEND_PLAY.
//   PEND_PLAY  [end] : end Vsync leading edge -> PLAY.
//  Blink: in OVER_FLASH, colours are forced to 0 when (frame_cnt / BLINK_FRAMES) is odd.
//   Syncs are never blanked. Division uses a BLINK_FRAMES down-counter and a phase bit.
//  The switch takes effect on the same cycle as the edge: the output register loads the new source.
//  Syncs pass straight through (no re-timing). A one-frame disturbance on the monitor at a switch
//   is acceptable.
//  frame_cnt is 8 bits and saturates; it never wraps.
//  Ignored events:
//   Game_over_sig outside PLAY.
//   Restart_sig in PLAY/PEND_OVER/PEND_PLAY.
//   Restart_sig coinciding with Game_over_sig in PLAY (game-over wins).
//  Unused state encodings recover to PLAY on the next clock.
// STRUCTURE
//  Shared package: the screen-state localparams (PLAY, PEND_OVER, OVER_FLASH, OVER, PEND_PLAY)
//   and the 800x600 timing constants used by both sync generators.
//  One natural sub-module, vga_vsync_edge: registered leading-edge detector, instantiated per source.
//  Remainder in a single module: FSM, frame/blink counters, output mux + register.
// TESTING (bench: two free-running 800x600 sync models, game colours=1-0-0, end colours=0-0-1)
//  1 Reset mid-line with colours=1 -> all colours 0 and syncs inactive immediately; state PLAY.
//  2 Game_over_sig=1 mid-frame -> pins keep game colours until the game Vsync edge; the next cycle
//    shows end colours; end_active=1.
//  3 BLINK_FRAMES=2, FLASH_FRAMES=6 -> blue visible in frames 0-1 and 4-5, blank in frames 2-3;
//    Flash_over_sig pulses once at the 6th edge; steady blue afterwards.
//  4 Restart_sig in OVER -> end source held until the next end Vsync edge, then game source;
//    end_active falls on that cycle.
//  5 Restart_sig on the same cycle as the FLASH_FRAMES exit -> PEND_PLAY; no Flash_over_sig pulse.
//  6 Restart_sig in PLAY, then Game_over_sig toggled inside PEND_PLAY -> both ignored; no state change.

Source files
------------

// File: rtl/vga_screen_select_pkg.sv
// Shared definitions for the VGA output-source selector: screen states and
// 800x600 @ 40 MHz timing constants shared with the sync generators.
package vga_screen_select_pkg;

  typedef enum logic [2:0] {
    PLAY       = 3'd0,
    PEND_OVER  = 3'd1,
    OVER_FLASH = 3'd2,
    OVER       = 3'd3,
    PEND_PLAY  = 3'd4
  } screen_state_e;

  localparam int H_VISIBLE = 800;
  localparam int H_FRONT   = 40;
  localparam int H_SYNC    = 128;
  localparam int H_BACK    = 88;
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  localparam int V_VISIBLE = 600;
  localparam int V_FRONT   = 1;
  localparam int V_SYNC    = 4;
  localparam int V_BACK    = 23;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam int FRAME_CNT_W = 8;

  // States in which the end-screen pipeline owns the VGA pins.
  function automatic logic is_end_source(input screen_state_e st);
    return (st == OVER_FLASH) || (st == OVER) || (st == PEND_PLAY);
  endfunction

endpackage

// File: rtl/vga_screen_select_vsync_edge.sv
// Leading-edge detector for one source's Vsync; the edge output is combinational
// from the current input and the registered previous level.
module vga_vsync_edge
  import vga_screen_select_pkg::*;
#(
  parameter bit SYNC_ACTIVE_HIGH = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_vsync,
  output logic o_lead_edge
);

  logic r_vsync_prev;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_vsync_prev <= ~SYNC_ACTIVE_HIGH;
    else       r_vsync_prev <= i_vsync;
  end

  assign o_lead_edge = (r_vsync_prev == ~SYNC_ACTIVE_HIGH) && (i_vsync == SYNC_ACTIVE_HIGH);

endmodule

// File: rtl/vga_screen_select.sv
// Selects the game or end-screen VGA pipeline, switching only on the current
// source's Vsync leading edge, and blinks the end screen before holding it.
module vga_screen_select
  import vga_screen_select_pkg::*;
#(
  parameter bit SYNC_ACTIVE_HIGH = 1'b1,
  parameter int BLINK_FRAMES     = 15,
  parameter int FLASH_FRAMES     = 120
) (
  input  logic CLK_40M,
  input  logic RST,
  input  logic Game_over_sig,
  input  logic Restart_sig,
  input  logic game_Vga_red,
  input  logic game_Vga_green,
  input  logic game_Vga_blue,
  input  logic game_Hsync_sig,
  input  logic game_Vsync_sig,
  input  logic end_Vga_red,
  input  logic end_Vga_green,
  input  logic end_Vga_blue,
  input  logic end_Hsync_sig,
  input  logic end_Vsync_sig,
  output logic Vga_red,
  output logic Vga_green,
  output logic Vga_blue,
  output logic Hsync_sig,
  output logic Vsync_sig,
  output logic end_active,
  output logic Flash_over_sig
);

  localparam logic [FRAME_CNT_W-1:0] BLINK_RELOAD = FRAME_CNT_W'(BLINK_FRAMES - 1);
  localparam logic [FRAME_CNT_W-1:0] FLASH_LAST   = FRAME_CNT_W'(FLASH_FRAMES);

  function automatic logic [FRAME_CNT_W-1:0] sat_inc(input logic [FRAME_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  screen_state_e           r_state, w_state_nxt;
  logic [FRAME_CNT_W-1:0]  r_frame_cnt, w_frame_cnt_nxt;
  logic [FRAME_CNT_W-1:0]  r_blink_cnt, w_blink_cnt_nxt;
  logic                    r_blink_phase, w_blink_phase_nxt;
  logic                    w_game_edge, w_end_edge;
  logic                    w_sel_end_p0, w_blank_p0;
  logic                    w_red_p0, w_green_p0, w_blue_p0, w_hs_p0, w_vs_p0;
  logic                    r_red_p1, r_green_p1, r_blue_p1, r_hs_p1, r_vs_p1;
  logic                    r_end_active_p1, r_flash_over_p1;

  vga_vsync_edge #(.SYNC_ACTIVE_HIGH(SYNC_ACTIVE_HIGH)) u_game_edge (
    .i_clk       (CLK_40M),
    .i_rst       (RST),
    .i_vsync     (game_Vsync_sig),
    .o_lead_edge (w_game_edge)
  );

  vga_vsync_edge #(.SYNC_ACTIVE_HIGH(SYNC_ACTIVE_HIGH)) u_end_edge (
    .i_clk       (CLK_40M),
    .i_rst       (RST),
    .i_vsync     (end_Vsync_sig),
    .o_lead_edge (w_end_edge)
  );

  always_comb begin
    w_state_nxt       = r_state;
    w_frame_cnt_nxt   = r_frame_cnt;
    w_blink_cnt_nxt   = r_blink_cnt;
    w_blink_phase_nxt = r_blink_phase;
    case (r_state)
      PLAY: begin
        if (Game_over_sig) w_state_nxt = PEND_OVER;
      end
      PEND_OVER: begin
        if (w_game_edge) begin
          w_state_nxt       = OVER_FLASH;
          w_frame_cnt_nxt   = '0;
          w_blink_cnt_nxt   = BLINK_RELOAD;
          w_blink_phase_nxt = 1'b0;
        end
      end
      OVER_FLASH: begin
        // The blink phase flips each time the down-counter wraps, giving frame_cnt / BLINK_FRAMES parity.
        if (w_end_edge) begin
          w_frame_cnt_nxt = sat_inc(r_frame_cnt);
          if (r_blink_cnt == '0) begin
            w_blink_cnt_nxt   = BLINK_RELOAD;
            w_blink_phase_nxt = ~r_blink_phase;
          end else begin
            w_blink_cnt_nxt = r_blink_cnt - 1'b1;
          end
        end
        if (Restart_sig)                         w_state_nxt = PEND_PLAY;
        else if (w_frame_cnt_nxt >= FLASH_LAST)  w_state_nxt = OVER;
      end
      OVER: begin
        if (Restart_sig) w_state_nxt = PEND_PLAY;
      end
      PEND_PLAY: begin
        if (w_end_edge) w_state_nxt = PLAY;
      end
      default: w_state_nxt = PLAY;
    endcase
  end

  // Stage p0: source mux driven by the next state, so a switch lands on the edge cycle itself.
  always_comb begin
    w_sel_end_p0 = is_end_source(w_state_nxt);
    w_blank_p0   = (w_state_nxt == OVER_FLASH) && w_blink_phase_nxt;
    w_red_p0     = w_sel_end_p0 ? end_Vga_red   : game_Vga_red;
    w_green_p0   = w_sel_end_p0 ? end_Vga_green : game_Vga_green;
    w_blue_p0    = w_sel_end_p0 ? end_Vga_blue  : game_Vga_blue;
    w_hs_p0      = w_sel_end_p0 ? end_Hsync_sig : game_Hsync_sig;
    w_vs_p0      = w_sel_end_p0 ? end_Vsync_sig : game_Vsync_sig;
    if (w_blank_p0) begin
      w_red_p0   = 1'b0;
      w_green_p0 = 1'b0;
      w_blue_p0  = 1'b0;
    end
  end

  always_ff @(posedge CLK_40M or posedge RST) begin
    if (RST) begin
      r_state       <= PLAY;
      r_frame_cnt   <= '0;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_frame_cnt   <= w_frame_cnt_nxt;
      r_blink_cnt   <= w_blink_cnt_nxt;
      r_blink_phase <= w_blink_phase_nxt;
    end
  end

  // Stage p1: registered pins.
  always_ff @(posedge CLK_40M or posedge RST) begin
    if (RST) begin
      r_red_p1        <= 1'b0;
      r_green_p1      <= 1'b0;
      r_blue_p1       <= 1'b0;
      r_hs_p1         <= ~SYNC_ACTIVE_HIGH;
      r_vs_p1         <= ~SYNC_ACTIVE_HIGH;
      r_end_active_p1 <= 1'b0;
      r_flash_over_p1 <= 1'b0;
    end else begin
      r_red_p1        <= w_red_p0;
      r_green_p1      <= w_green_p0;
      r_blue_p1       <= w_blue_p0;
      r_hs_p1         <= w_hs_p0;
      r_vs_p1         <= w_vs_p0;
      r_end_active_p1 <= w_sel_end_p0;
      r_flash_over_p1 <= (r_state == OVER_FLASH) && (w_state_nxt == OVER);
    end
  end

  assign Vga_red        = r_red_p1;
  assign Vga_green      = r_green_p1;
  assign Vga_blue       = r_blue_p1;
  assign Hsync_sig      = r_hs_p1;
  assign Vsync_sig      = r_vs_p1;
  assign end_active     = r_end_active_p1;
  assign Flash_over_sig = r_flash_over_p1;

endmodule

// File: tb/tb_vga_screen_select.sv
// Directed bench for vga_screen_select using two scaled-down free-running sync
// models (20 clocks per line, 12 lines per frame) with offset phases.
module tb_vga_screen_select;

  localparam int HT = 20;
  localparam int HS0 = 12;
  localparam int HS1 = 15;
  localparam int VT = 12;
  localparam int VS_LINE = 8;
  localparam int RED = 4;
  localparam int BLUE = 1;
  localparam int BLACK = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, game_over, restart;
  logic g_red = 1'b1, g_green = 1'b0, g_blue = 1'b0;
  logic e_red = 1'b0, e_green = 1'b0, e_blue = 1'b1;
  int   g_h = 0, g_v = 0, e_h = 7, e_v = 3;
  logic g_hs, g_vs, e_hs, e_vs, g_edge_next, e_edge_next;
  logic g_hs_q = 1'b0, e_vs_q = 1'b0;
  int   flash_pulses = 0;
  int   checks = 0;
  int   failures = 0;

  logic Vga_red, Vga_green, Vga_blue, Hsync_sig, Vsync_sig, end_active, Flash_over_sig;

  assign g_hs = (g_h >= HS0) && (g_h < HS1);
  assign g_vs = (g_v == VS_LINE);
  assign e_hs = (e_h >= HS0) && (e_h < HS1);
  assign e_vs = (e_v == VS_LINE);
  assign g_edge_next = g_vs && (g_h == 0);
  assign e_edge_next = e_vs && (e_h == 0);

  always @(posedge clk) begin
    g_hs_q <= g_hs;
    e_vs_q <= e_vs;
    if (g_h == HT - 1) begin
      g_h <= 0;
      g_v <= (g_v == VT - 1) ? 0 : g_v + 1;
    end else begin
      g_h <= g_h + 1;
    end
    if (e_h == HT - 1) begin
      e_h <= 0;
      e_v <= (e_v == VT - 1) ? 0 : e_v + 1;
    end else begin
      e_h <= e_h + 1;
    end
    if (Flash_over_sig === 1'b1) flash_pulses <= flash_pulses + 1;
  end

  vga_screen_select #(
    .SYNC_ACTIVE_HIGH (1'b1),
    .BLINK_FRAMES     (2),
    .FLASH_FRAMES     (6)
  ) dut (
    .CLK_40M        (clk),
    .RST            (rst),
    .Game_over_sig  (game_over),
    .Restart_sig    (restart),
    .game_Vga_red   (g_red),
    .game_Vga_green (g_green),
    .game_Vga_blue  (g_blue),
    .game_Hsync_sig (g_hs),
    .game_Vsync_sig (g_vs),
    .end_Vga_red    (e_red),
    .end_Vga_green  (e_green),
    .end_Vga_blue   (e_blue),
    .end_Hsync_sig  (e_hs),
    .end_Vsync_sig  (e_vs),
    .Vga_red        (Vga_red),
    .Vga_green      (Vga_green),
    .Vga_blue       (Vga_blue),
    .Hsync_sig      (Hsync_sig),
    .Vsync_sig      (Vsync_sig),
    .end_active     (end_active),
    .Flash_over_sig (Flash_over_sig)
  );

  function automatic int rgb_now();
    return {29'd0, Vga_red, Vga_green, Vga_blue};
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Returns at the falling edge just before the posedge that sees the chosen Vsync leading edge.
  task automatic wait_edge(input bit use_end);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 400 && !hit; i++) begin
      @(negedge clk);
      hit = use_end ? e_edge_next : g_edge_next;
    end
    chk1("vsync_edge_reached", hit, 1'b1);
  endtask

  task automatic wait_pos(input bit use_end, input int v, input int h);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 400 && !hit; i++) begin
      @(negedge clk);
      hit = use_end ? (e_v == v && e_h == h) : (g_v == v && g_h == h);
    end
    chk1("position_reached", hit, 1'b1);
  endtask

  initial begin
    int exp_frame [0:5];
    exp_frame = '{BLUE, BLUE, BLACK, BLACK, BLUE, BLUE};
    rst = 1'b1;
    game_over = 1'b0;
    restart = 1'b0;

    repeat (3) @(negedge clk);
    chkv("reset_rgb", rgb_now(), BLACK);
    chk1("reset_hsync", Hsync_sig, 1'b0);
    chk1("reset_vsync", Vsync_sig, 1'b0);
    chk1("reset_end_active", end_active, 1'b0);
    chk1("reset_flash", Flash_over_sig, 1'b0);
    rst = 1'b0;

    // Game source in PLAY, inside the game hsync pulse.
    wait_pos(1'b0, 2, 14);
    chkv("play_rgb", rgb_now(), RED);
    chk1("play_hsync", Hsync_sig, 1'b1);
    chk1("play_vsync", Vsync_sig, 1'b0);

    // Asynchronous reset mid-line.
    #2 rst = 1'b1;
    #1;
    chkv("async_reset_rgb", rgb_now(), BLACK);
    chk1("async_reset_hsync", Hsync_sig, 1'b0);
    chk1("async_reset_end_active", end_active, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chkv("post_reset_rgb", rgb_now(), RED);
    chk1("post_reset_hsync", Hsync_sig, g_hs_q);

    // Game over mid-frame: game colours hold until the game Vsync edge.
    wait_pos(1'b0, 4, 5);
    game_over = 1'b1;
    @(negedge clk);
    chkv("pend_over_rgb", rgb_now(), RED);
    chk1("pend_over_end_active", end_active, 1'b0);
    wait_edge(1'b0);
    chkv("pre_switch_rgb", rgb_now(), RED);
    @(negedge clk);
    game_over = 1'b0;
    chkv("switch_rgb", rgb_now(), BLUE);
    chk1("switch_end_active", end_active, 1'b1);
    chk1("switch_vsync_from_end", Vsync_sig, e_vs_q);

    // Blink: BLINK_FRAMES=2, FLASH_FRAMES=6.
    for (int k = 1; k <= 6; k++) begin
      wait_edge(1'b1);
      chkv("blink_frame_tail", rgb_now(), exp_frame[k-1]);
      @(negedge clk);
      chk1("blink_end_active", end_active, 1'b1);
      if (k < 6) begin
        chkv("blink_frame_head", rgb_now(), exp_frame[k]);
        chk1("blink_no_flash", Flash_over_sig, 1'b0);
      end else begin
        chkv("over_rgb", rgb_now(), BLUE);
        chk1("flash_pulse", Flash_over_sig, 1'b1);
      end
      if (k == 2) begin
        wait_pos(1'b1, 9, 14);
        chkv("blank_rgb", rgb_now(), BLACK);
        chk1("blank_hsync_passes", Hsync_sig, 1'b1);
      end
    end
    @(negedge clk);
    chk1("flash_pulse_ends", Flash_over_sig, 1'b0);

    // Restart in OVER: end source held until the next end Vsync edge.
    wait_pos(1'b1, 2, 3);
    chkv("over_steady_rgb", rgb_now(), BLUE);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    chkv("pend_play_rgb", rgb_now(), BLUE);
    chk1("pend_play_end_active", end_active, 1'b1);
    wait_edge(1'b1);
    chkv("pre_return_rgb", rgb_now(), BLUE);
    @(negedge clk);
    chkv("return_rgb", rgb_now(), RED);
    chk1("return_end_active", end_active, 1'b0);
    chkv("flash_pulse_count", flash_pulses, 1);

    // Restart in PLAY is ignored.
    wait_pos(1'b0, 3, 3);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    chkv("restart_in_play_rgb", rgb_now(), RED);
    wait_edge(1'b0);
    @(negedge clk);
    chkv("restart_in_play_after_edge_rgb", rgb_now(), RED);
    chk1("restart_in_play_end_active", end_active, 1'b0);

    // Restart coinciding with the FLASH_FRAMES exit wins.
    game_over = 1'b1;
    wait_edge(1'b0);
    @(negedge clk);
    game_over = 1'b0;
    chkv("second_switch_rgb", rgb_now(), BLUE);
    for (int k = 1; k <= 5; k++) begin
      wait_edge(1'b1);
      @(negedge clk);
    end
    wait_edge(1'b1);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    chk1("exit_restart_no_flash", Flash_over_sig, 1'b0);
    chk1("exit_restart_end_active", end_active, 1'b1);
    chkv("exit_restart_rgb", rgb_now(), BLUE);

    // Game over toggled inside PEND_PLAY is ignored.
    wait_pos(1'b1, 2, 0);
    game_over = 1'b1;
    repeat (3) @(negedge clk);
    game_over = 1'b0;
    chkv("pend_play_game_over_rgb", rgb_now(), BLUE);
    chk1("pend_play_game_over_end_active", end_active, 1'b1);
    wait_edge(1'b1);
    @(negedge clk);
    chkv("second_return_rgb", rgb_now(), RED);
    chk1("second_return_end_active", end_active, 1'b0);
    repeat (3) @(negedge clk);
    chkv("flash_pulse_total", flash_pulses, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
